// File: rtl/uart_pkg.sv
// uart_pkg: shared definitions for the UART receive monitor.
//   rx_state_e  - receiver FSM states
//   DATA_BITS   - payload bits per 8N1 frame
//   IDLE_LEVEL  - level of an idle serial line (also the synchronizer reset value)
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    BREAK
  } rx_state_e;

  localparam int   DATA_BITS  = 8;
  localparam logic IDLE_LEVEL = 1'b1;

endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO with show-ahead (combinational) read of the head.
//   clk_i     - clock
//   rst_ni    - asynchronous reset, active-low (empties the FIFO)
//   push_i    - write request; din_i is the data
//   pop_i     - read request; ignored while empty
//   dout_o    - entry at the head (0 while empty)
//   valid_o   - FIFO non-empty
//   accept_o  - push_i was taken this cycle
//   drop_o    - push_i was refused because the FIFO was full with no pop
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int AW    = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [WIDTH-1:0] din_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] dout_o,
  output logic             valid_o,
  output logic             accept_o,
  output logic             drop_o
);

  // One extra pointer bit distinguishes full from empty when the low bits match.
  logic [AW:0]      wr_ptr_q;
  logic [AW:0]      rd_ptr_q;
  logic [WIDTH-1:0] mem_q [2**AW];

  logic empty;
  logic full;
  logic pop_en;

  assign empty  = (wr_ptr_q == rd_ptr_q);
  assign full   = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                  (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign pop_en = pop_i && !empty;

  // A simultaneous pop frees the head slot, so a push into a full FIFO still fits.
  assign accept_o = push_i && (!full || pop_en);
  assign drop_o   = push_i && full && !pop_en;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (accept_o) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_en)   rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  // Storage carries no reset; emptiness is tracked by the pointers alone.
  always_ff @(posedge clk_i) begin
    if (accept_o) mem_q[wr_ptr_q[AW-1:0]] <= din_i;
  end

  assign valid_o = !empty;
  assign dout_o  = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];

endmodule

// File: rtl/uart_rx_monitor.sv
// uart_rx_monitor: recovers 8N1 bytes from a serial line into a show-ahead FIFO.
//   clk_in          - system clock
//   rst_in_n        - asynchronous reset, active-low; aborts any frame in flight
//   rx_in           - serial line, idle high
//   dout_out        - byte at FIFO head; dout_valid_out - FIFO non-empty
//   dout_ready_in   - pop, effective only while dout_valid_out=1
//   clr_err_in      - clears both sticky flags (a same-cycle set wins)
//   frame_err_out   - sticky: a stop bit was sampled low
//   overflow_out    - sticky: a byte was dropped on a full FIFO
//   byte_cnt_out    - bytes accepted into the FIFO, wraps at 2^32
module uart_rx_monitor
  import uart_pkg::*;
#(
  parameter int BAUD_DIV = 868,  // clock cycles per bit, at least 4
  parameter int FIFO_AW  = 4
) (
  input  logic        clk_in,
  input  logic        rst_in_n,
  input  logic        rx_in,
  output logic [7:0]  dout_out,
  output logic        dout_valid_out,
  input  logic        dout_ready_in,
  input  logic        clr_err_in,
  output logic        frame_err_out,
  output logic        overflow_out,
  output logic [31:0] byte_cnt_out
);

  localparam int CNT_W = $clog2(BAUD_DIV);
  localparam logic [CNT_W-1:0] HALF_CNT = CNT_W'(BAUD_DIV / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(BAUD_DIV - 1);
  localparam logic [2:0]       LAST_BIT = 3'(DATA_BITS - 1);

  // Two-flop synchronizer plus one more flop for falling-edge detection.
  logic [1:0] sync_q;
  logic       rxs;
  logic       rxs_prev_q;

  always_ff @(posedge clk_in or negedge rst_in_n) begin
    if (!rst_in_n) begin
      sync_q     <= {2{IDLE_LEVEL}};
      rxs_prev_q <= IDLE_LEVEL;
    end else begin
      sync_q     <= {sync_q[0], rx_in};
      rxs_prev_q <= sync_q[1];
    end
  end

  assign rxs = sync_q[1];

  rx_state_e              state_q;
  logic [CNT_W-1:0]       baud_cnt_q;
  logic [2:0]             bit_idx_q;
  logic [DATA_BITS-1:0]   shift_q;

  always_ff @(posedge clk_in or negedge rst_in_n) begin
    if (!rst_in_n) begin
      state_q    <= IDLE;
      baud_cnt_q <= '0;
      bit_idx_q  <= '0;
      shift_q    <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (rxs_prev_q && !rxs) begin
            state_q    <= START;
            baud_cnt_q <= HALF_CNT;
          end
        end
        START: begin
          if (baud_cnt_q == '0) begin
            // Mid start bit: a high line means the edge was a glitch.
            if (rxs) begin
              state_q <= IDLE;
            end else begin
              state_q    <= DATA;
              baud_cnt_q <= FULL_CNT;
              bit_idx_q  <= '0;
            end
          end else begin
            baud_cnt_q <= baud_cnt_q - 1'b1;
          end
        end
        DATA: begin
          if (baud_cnt_q == '0) begin
            shift_q[bit_idx_q] <= rxs;
            baud_cnt_q         <= FULL_CNT;
            bit_idx_q          <= bit_idx_q + 3'd1;
            if (bit_idx_q == LAST_BIT) state_q <= STOP;
          end else begin
            baud_cnt_q <= baud_cnt_q - 1'b1;
          end
        end
        STOP: begin
          if (baud_cnt_q == '0) begin
            state_q <= rxs ? IDLE : BREAK;
          end else begin
            baud_cnt_q <= baud_cnt_q - 1'b1;
          end
        end
        BREAK: begin
          if (rxs) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // The byte is handed to the FIFO during the stop-sample cycle itself, so it
  // appears at the head on the following cycle.
  logic stop_sample;
  logic push;
  logic frame_set;
  logic accept;
  logic drop;

  assign stop_sample = (state_q == STOP) && (baud_cnt_q == '0);
  assign push        = stop_sample && rxs;
  assign frame_set   = stop_sample && !rxs;

  sync_fifo #(
    .WIDTH (DATA_BITS),
    .AW    (FIFO_AW)
  ) u_fifo (
    .clk_i    (clk_in),
    .rst_ni   (rst_in_n),
    .push_i   (push),
    .din_i    (shift_q),
    .pop_i    (dout_ready_in),
    .dout_o   (dout_out),
    .valid_o  (dout_valid_out),
    .accept_o (accept),
    .drop_o   (drop)
  );

  logic        frame_err_q, frame_err_d;
  logic        overflow_q,  overflow_d;
  logic [31:0] byte_cnt_q,  byte_cnt_d;

  // Clear is applied first so that a set in the same cycle takes priority.
  always_comb begin
    frame_err_d = frame_err_q;
    overflow_d  = overflow_q;
    byte_cnt_d  = byte_cnt_q;
    if (clr_err_in) begin
      frame_err_d = 1'b0;
      overflow_d  = 1'b0;
    end
    if (frame_set) frame_err_d = 1'b1;
    if (drop)      overflow_d  = 1'b1;
    if (accept)    byte_cnt_d  = byte_cnt_q + 32'd1;
  end

  always_ff @(posedge clk_in or negedge rst_in_n) begin
    if (!rst_in_n) begin
      frame_err_q <= 1'b0;
      overflow_q  <= 1'b0;
      byte_cnt_q  <= '0;
    end else begin
      frame_err_q <= frame_err_d;
      overflow_q  <= overflow_d;
      byte_cnt_q  <= byte_cnt_d;
    end
  end

  assign frame_err_out = frame_err_q;
  assign overflow_out  = overflow_q;
  assign byte_cnt_out  = byte_cnt_q;

endmodule

// File: tb/tb_uart_rx_monitor.sv
// tb_uart_rx_monitor: randomized self-checking bench for uart_rx_monitor.
// A queue-based model tracks which bytes should sit in the FIFO, the byte
// count and the sticky flags; each scenario task compares the DUT against it.
module tb_uart_rx_monitor;

  localparam int BAUD_DIV  = 8;
  localparam int FIFO_AW   = 4;
  localparam int DEPTH     = 2 ** FIFO_AW;
  localparam int FRAME_CYC = 10 * BAUD_DIV;
  // Frames start on a falling clock edge (index 0). Two synchronizer flops and
  // the edge-detect register put the FSM in START after rising edge 3; then
  // half a start bit, eight data bits and half... rounded to whole bit periods:
  // BAUD_DIV/2 + 8*BAUD_DIV + BAUD_DIV cycles to the stop sample. The stop
  // sample is therefore taken at rising edge STOP_CYC and the byte is visible
  // from falling edge STOP_CYC onward.
  localparam int STOP_CYC  = 3 + BAUD_DIV / 2 + 9 * BAUD_DIV;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        rx;
  logic        ready;
  logic        clr;
  logic [7:0]  dout;
  logic        valid;
  logic        ferr;
  logic        ovf;
  logic [31:0] cnt;

  int checks = 0;
  int errors = 0;

  logic [7:0]  mq[$];
  logic [31:0] m_cnt;
  logic        m_ferr;
  logic        m_ovf;

  always #5 clk = ~clk;

  uart_rx_monitor #(
    .BAUD_DIV (BAUD_DIV),
    .FIFO_AW  (FIFO_AW)
  ) dut (
    .clk_in         (clk),
    .rst_in_n       (rst_n),
    .rx_in          (rx),
    .dout_out       (dout),
    .dout_valid_out (valid),
    .dout_ready_in  (ready),
    .clr_err_in     (clr),
    .frame_err_out  (ferr),
    .overflow_out   (ovf),
    .byte_cnt_out   (cnt)
  );

  function automatic void model_reset();
    mq.delete();
    m_cnt  = '0;
    m_ferr = 1'b0;
    m_ovf  = 1'b0;
  endfunction

  // One complete frame as seen by the receiver: optional clear and pop in the
  // stop-sample cycle, then the frame outcome (clear before set, pop before push).
  function automatic void model_frame(input logic [7:0] b, input logic stop_bit,
                                      input bit pop_same, input bit clr_same);
    logic [7:0] tmp;
    if (clr_same) begin
      m_ferr = 1'b0;
      m_ovf  = 1'b0;
    end
    if (pop_same && mq.size() > 0) tmp = mq.pop_front();
    if (!stop_bit) m_ferr = 1'b1;
    else if (mq.size() < DEPTH) begin
      mq.push_back(b);
      m_cnt = m_cnt + 32'd1;
    end else m_ovf = 1'b1;
  endfunction

  // Drive one 8N1 frame. strobe: 0 none, 1 pop in the stop-sample cycle,
  // 2 clear-errors in the stop-sample cycle. chk_rise checks the valid latency
  // (only meaningful when the FIFO starts empty).
  task automatic send_frame(input logic [7:0] b, input logic stop_bit,
                            input int strobe, input bit chk_rise);
    logic [9:0] bits;
    bits = {stop_bit, b, 1'b0};
    $display("tx byte 0x%02h stop=%0b strobe=%0d", b, stop_bit, strobe);
    for (int c = 0; c < FRAME_CYC; c++) begin
      if (chk_rise && c == STOP_CYC - 1) begin
        checks++;
        if (valid !== 1'b0) begin
          errors++;
          $display("FAIL valid_early: got %b expected 0", valid);
        end
      end
      if (chk_rise && c == STOP_CYC) begin
        checks++;
        if (valid !== 1'b1 || dout !== b) begin
          errors++;
          $display("FAIL valid_rise: got valid=%b dout=%02h expected valid=1 dout=%02h",
                   valid, dout, b);
        end
      end
      if (strobe == 1 && c == STOP_CYC - 1 && mq.size() > 0) begin
        checks++;
        if (dout !== mq[0]) begin
          errors++;
          $display("FAIL head_at_pop: got %02h expected %02h", dout, mq[0]);
        end
      end
      rx    = bits[c / BAUD_DIV];
      ready = (strobe == 1) && (c == STOP_CYC - 1);
      clr   = (strobe == 2) && (c == STOP_CYC - 1);
      @(negedge clk);
    end
    ready = 1'b0;
    clr   = 1'b0;
    model_frame(b, stop_bit, strobe == 1, strobe == 2);
  endtask

  task automatic idle_cycles(input int n);
    rx = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_clr();
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    m_ferr = 1'b0;
    m_ovf  = 1'b0;
  endtask

  task automatic pop_one(input string tag);
    logic [7:0] tmp;
    checks++;
    if (valid !== (mq.size() > 0) || (mq.size() > 0 && dout !== mq[0])) begin
      errors++;
      $display("FAIL %s pop: got valid=%b dout=%02h expected valid=%0d dout=%02h",
               tag, valid, dout, mq.size() > 0, (mq.size() > 0) ? mq[0] : 8'h00);
    end
    ready = 1'b1;
    @(negedge clk);
    ready = 1'b0;
    if (mq.size() > 0) tmp = mq.pop_front();
  endtask

  task automatic drain(input string tag);
    while (mq.size() > 0) pop_one(tag);
    checks++;
    if (valid !== 1'b0 || dout !== 8'h00) begin
      errors++;
      $display("FAIL %s empty: got valid=%b dout=%02h expected valid=0 dout=00",
               tag, valid, dout);
    end
  endtask

  task automatic check_status(input string tag);
    checks++;
    if (cnt !== m_cnt || ferr !== m_ferr || ovf !== m_ovf) begin
      errors++;
      $display("FAIL %s status: got cnt=%0d ferr=%b ovf=%b expected cnt=%0d ferr=%b ovf=%b",
               tag, cnt, ferr, ovf, m_cnt, m_ferr, m_ovf);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    rx    = 1'b1;
    ready = 1'b0;
    clr   = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    checks++;
    if (valid !== 1'b0 || dout !== 8'h00 || ferr !== 1'b0 || ovf !== 1'b0 || cnt !== 32'd0) begin
      errors++;
      $display("FAIL reset_values: got valid=%b dout=%02h ferr=%b ovf=%b cnt=%0d expected all 0",
               valid, dout, ferr, ovf, cnt);
    end
    rst_n = 1'b1;
    idle_cycles(5);
    check_status("after_reset");
  endtask

  task automatic test_single_byte();
    send_frame(8'hA5, 1'b1, 0, 1'b1);
    check_status("single");
    idle_cycles(6);
    checks++;
    if (valid !== 1'b1 || dout !== 8'hA5) begin
      errors++;
      $display("FAIL single_stable: got valid=%b dout=%02h expected valid=1 dout=a5", valid, dout);
    end
    drain("single");
  endtask

  task automatic test_false_start();
    logic [31:0] cnt_before;
    cnt_before = m_cnt;
    rx = 1'b0;
    repeat (3) @(negedge clk);
    idle_cycles(20);
    checks++;
    if (valid !== 1'b0 || cnt !== cnt_before || ferr !== 1'b0) begin
      errors++;
      $display("FAIL false_start: got valid=%b cnt=%0d ferr=%b expected valid=0 cnt=%0d ferr=0",
               valid, cnt, ferr, cnt_before);
    end
    // A proper frame right after shows the receiver is back in idle.
    send_frame(8'h5A, 1'b1, 0, 1'b1);
    drain("false_start");
  endtask

  task automatic test_frame_error();
    send_frame(8'h3C, 1'b0, 0, 1'b0);
    rx = 1'b0;
    repeat (20) @(negedge clk);
    idle_cycles(10);
    send_frame(8'h41, 1'b1, 0, 1'b0);
    check_status("frame_err");
    drain("frame_err");
    pulse_clr();
    check_status("frame_err_clr");
    // Set must win over a clear in the same cycle.
    send_frame(8'h99, 1'b0, 2, 1'b0);
    idle_cycles(12);
    check_status("set_wins");
    pulse_clr();
    check_status("set_wins_clr");
  endtask

  task automatic test_overflow();
    for (int i = 0; i <= DEPTH; i++) begin
      send_frame(8'(i), 1'b1, 0, 1'b0);
      if (i == DEPTH - 1) check_status("fill_full");
    end
    check_status("overflow");
    drain("overflow");
    pulse_clr();
    check_status("overflow_clr");
  endtask

  task automatic test_full_pop();
    for (int i = 0; i < DEPTH; i++) send_frame(8'($urandom_range(0, 255)), 1'b1, 0, 1'b0);
    send_frame(8'($urandom_range(0, 255)), 1'b1, 1, 1'b0);
    check_status("full_pop");
    drain("full_pop");
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 4; i++) send_frame(8'($urandom_range(0, 255)), 1'b1, 0, 1'b0);
    check_status("back_to_back");
    drain("back_to_back");
  endtask

  task automatic test_random();
    for (int t = 0; t < 12; t++) begin
      send_frame(8'($urandom_range(0, 255)), 1'b1, 0, 1'b0);
      idle_cycles($urandom_range(0, 5));
      repeat ($urandom_range(0, 2)) pop_one("random");
      check_status("random");
    end
    drain("random");
  endtask

  task automatic test_reset_mid_frame();
    logic [9:0] bits;
    bits = {1'b1, 8'h55, 1'b0};
    $display("tx byte 0x55 aborted by reset");
    for (int c = 0; c < 4 * BAUD_DIV; c++) begin
      rx = bits[c / BAUD_DIV];
      @(negedge clk);
    end
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    idle_cycles(12);
    send_frame(8'h7E, 1'b1, 0, 1'b1);
    check_status("reset_mid");
    drain("reset_mid");
  endtask

  initial begin
    test_reset();
    test_single_byte();
    test_false_start();
    test_frame_error();
    test_overflow();
    test_full_pop();
    test_back_to_back();
    test_random();
    test_reset_mid_frame();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
